decimal_encoder_debounce: RTL

- Inverse of the BCD-to-decimal demux: takes ten asynchronous active-low decimal lines and produces a synchronized, debounced, 74147-style priority-encoded BCD code.
- Used on switch, coin and test inputs that the original board encoded in discrete logic.
- Each change of the encoded result is offered to the CPU-side glue as a one-deep valid/ready event, with overrun reporting.

---
 rtl/decimal_encoder_debounce_pkg.sv | 27 ++
 rtl/decimal_encoder_debounce_sync_debounce.sv | 52 +++++
 rtl/decimal_encoder_debounce.sv | 80 ++++++++
 3 files changed

// File: rtl/decimal_encoder_debounce_pkg.sv
// Shared definitions for the decimal-line encode path and the BCD demux decode path.
package decimal_encoder_debounce_pkg;

  localparam int unsigned DECIMAL_LINES = 10;
  localparam int unsigned BCD_WIDTH     = 4;

  typedef logic [BCD_WIDTH-1:0] bcd_t;

  typedef struct packed {
    bcd_t code;
    logic any;
  } enc_t;

  // Ascending scan so the highest active (low) line wins, 74147-style.
  function automatic enc_t prio_encode(input logic [DECIMAL_LINES-1:0] lines_n);
    enc_t r;
    r = '0;
    for (int unsigned i = 0; i < DECIMAL_LINES; i++) begin
      if (!lines_n[i]) begin
        r.code = bcd_t'(i);
        r.any  = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/decimal_encoder_debounce_sync_debounce.sv
// Multi-stage synchronizer followed by a sample-qualified debounce of the whole vector.
module sync_debounce #(
  parameter int unsigned WIDTH           = 10,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_sample_en,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_stable
);

  localparam int unsigned        CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]                  r_cand;
  logic [WIDTH-1:0]                  r_stable;
  logic [CNT_W-1:0]                  r_cnt;
  logic [WIDTH-1:0]                  w_raw;

  assign w_raw    = r_sync[SYNC_STAGES-1];
  assign o_stable = r_stable;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
    end
  end

  // A raw change always restarts qualification; the count saturates at CNT_LAST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cand   <= '1;
      r_stable <= '1;
      r_cnt    <= '0;
    end else if (w_raw != r_cand) begin
      r_cand <= w_raw;
      r_cnt  <= '0;
    end else if (i_sample_en) begin
      if (r_cnt < CNT_LAST) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_stable <= r_cand;
      end
    end
  end

endmodule

// File: rtl/decimal_encoder_debounce.sv
// Debounced priority encoder for ten active-low decimal lines with a one-deep change-event slot.
module decimal_encoder_debounce
  import decimal_encoder_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DECIMAL_LINES-1:0] d_n,
  input  logic                     sample_en,
  output bcd_t                     code,
  output logic                     any,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output bcd_t                     evt_code,
  output logic                     evt_any,
  output logic                     evt_overrun
);

  logic [DECIMAL_LINES-1:0] w_stable;
  enc_t                     w_enc;
  logic                     w_change;

  bcd_t r_code;
  logic r_any;
  logic r_evt_valid;
  bcd_t r_evt_code;
  logic r_evt_any;
  logic r_evt_overrun;

  sync_debounce #(
    .WIDTH           (DECIMAL_LINES),
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sync_debounce (
    .clk         (clk),
    .rst         (reset),
    .i_sample_en (sample_en),
    .i_din       (d_n),
    .o_stable    (w_stable)
  );

  always_comb begin
    w_enc    = prio_encode(w_stable);
    w_change = (w_enc != {r_code, r_any});
  end

  // Overrun flags only an overwrite of an unconsumed event; a same-edge consume clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_code        <= '0;
      r_any         <= 1'b0;
      r_evt_valid   <= 1'b0;
      r_evt_code    <= '0;
      r_evt_any     <= 1'b0;
      r_evt_overrun <= 1'b0;
    end else begin
      r_code <= w_enc.code;
      r_any  <= w_enc.any;
      if (w_change) begin
        r_evt_valid   <= 1'b1;
        r_evt_code    <= w_enc.code;
        r_evt_any     <= w_enc.any;
        r_evt_overrun <= r_evt_valid & ~evt_ready;
      end else if (r_evt_valid && evt_ready) begin
        r_evt_valid   <= 1'b0;
        r_evt_overrun <= 1'b0;
      end
    end
  end

  assign code        = r_code;
  assign any         = r_any;
  assign evt_valid   = r_evt_valid;
  assign evt_code    = r_evt_code;
  assign evt_any     = r_evt_any;
  assign evt_overrun = r_evt_overrun;

endmodule
